// File: rtl/lsu_pkg.sv
// Shared types and the load-data extraction helper for the LSU writeback path.
// Extraction is shared by every lane so that all lanes flag misalignment the same way.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } lsu_wb_entry_t;

  typedef struct packed {
    logic        ok;
    logic [31:0] data;
  } lsu_ext_t;

  // ok=0 for an illegal size, misaligned H/W, or an unsigned word load.
  function automatic lsu_ext_t lsu_extract(input logic [31:0] data, input logic [1:0] off,
                                           input size_e size, input logic zext);
    lsu_ext_t    res;
    logic [7:0]  b;
    logic [15:0] h;
    b        = data[{off, 3'b000} +: 8];
    h        = data[{off[1], 4'b0000} +: 16];
    res.ok   = 1'b0;
    res.data = '0;
    case (size)
      SZ_B: begin
        res.ok   = 1'b1;
        res.data = {{24{b[7] & ~zext}}, b};
      end
      SZ_H: begin
        res.ok   = ~off[0];
        res.data = {{16{h[15] & ~zext}}, h};
      end
      SZ_W: begin
        res.ok   = (off == 2'd0) && !zext;
        res.data = data;
      end
      default: res.ok = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_wb_pipe_if.sv
// Memory-response and regfile-write bundle for all lanes of lsu_wb_pipe.
// slave = the writeback stage, master = the environment driving responses and accepting writes.
interface lsu_wb_pipe_if
  import lsu_pkg::*;
#(
  parameter int NUM_LANES = 2
) ();

  logic  [NUM_LANES-1:0]       rsp_valid;
  logic  [NUM_LANES-1:0]       rsp_ready;
  logic  [NUM_LANES-1:0]       rsp_is_load;
  logic  [NUM_LANES-1:0][4:0]  rsp_rd;
  logic  [NUM_LANES-1:0][1:0]  rsp_addr_lo;
  size_e [NUM_LANES-1:0]       rsp_size;
  logic  [NUM_LANES-1:0]       rsp_zext;
  logic  [NUM_LANES-1:0][31:0] rsp_data;

  logic  [NUM_LANES-1:0]       wr_valid;
  logic  [NUM_LANES-1:0]       wr_ready;
  logic  [NUM_LANES-1:0][4:0]  wr_rd;
  logic  [NUM_LANES-1:0][31:0] wr_data;

  modport slave (
    input  rsp_valid, rsp_is_load, rsp_rd, rsp_addr_lo, rsp_size, rsp_zext, rsp_data, wr_ready,
    output rsp_ready, wr_valid, wr_rd, wr_data
  );

  modport master (
    output rsp_valid, rsp_is_load, rsp_rd, rsp_addr_lo, rsp_size, rsp_zext, rsp_data, wr_ready,
    input  rsp_ready, wr_valid, wr_rd, wr_data
  );

endinterface

// File: rtl/lsu_wb_lane.sv
// One writeback lane: extract/extend the load, queue it in a DEPTH-entry FIFO, drain to the regfile.
// LSU_WB_BYPASS_EN: an accepted load skips an empty FIFO when the regfile port is ready.
module lsu_wb_lane
  import lsu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic        i_err_clr,
  input  logic        i_rsp_valid,
  output logic        o_rsp_ready,
  input  logic        i_rsp_is_load,
  input  logic [4:0]  i_rsp_rd,
  input  logic [1:0]  i_rsp_addr_lo,
  input  size_e       i_rsp_size,
  input  logic        i_rsp_zext,
  input  logic [31:0] i_rsp_data,
  output logic        o_wr_valid,
  input  logic        i_wr_ready,
  output logic [4:0]  o_wr_rd,
  output logic [31:0] o_wr_data,
  output logic        o_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  lsu_wb_entry_t    r_mem [DEPTH];
  lsu_wb_entry_t    r_last;
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ready, r_err;

  lsu_ext_t         w_ext;
  lsu_wb_entry_t    w_new, w_head, w_out;
  logic             w_accept, w_legal, w_push, w_pop, w_err_set, w_bypass, w_nonempty;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_ext      = lsu_extract(i_rsp_data, i_rsp_addr_lo, i_rsp_size, i_rsp_zext);
  assign w_new      = '{rd: i_rsp_rd, data: w_ext.data};
  assign w_head     = r_mem[r_rptr];
  assign w_nonempty = (r_count != '0);

  assign w_accept  = i_rsp_valid & r_ready;
  assign w_err_set = w_accept & i_rsp_is_load & ~w_ext.ok;
  // Stores, rd==0 loads and errored loads are consumed here but never queued.
  assign w_legal   = w_accept & i_rsp_is_load & w_ext.ok & (i_rsp_rd != 5'd0) & ~i_flush;

`ifdef LSU_WB_BYPASS_EN
  assign w_bypass = w_legal & ~w_nonempty & i_wr_ready;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push      = w_legal & ~w_bypass;
  assign w_pop       = w_nonempty & i_wr_ready;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_out = r_last;
    if (w_nonempty) w_out = w_head;
    else if (w_bypass) w_out = w_new;
  end

  assign o_wr_valid  = w_nonempty | w_bypass;
  assign o_wr_rd     = w_out.rd;
  assign o_wr_data   = w_out.data;
  assign o_rsp_ready = r_ready;
  assign o_err       = r_err;

  // NOTE: control state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ready <= 1'b1;
      r_last  <= '0;
      r_err   <= 1'b0;
    end else begin
      if (i_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
        r_ready <= 1'b1;
      end else begin
        if (w_push) r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
        r_count <= w_count_nxt;
        r_ready <= (w_count_nxt != CNT_W'(DEPTH));
      end
      if (w_pop)         r_last <= w_head;
      else if (w_bypass) r_last <= w_new;
      // A new error in the same cycle as err_clr must survive.
      if (w_err_set)      r_err <= 1'b1;
      else if (i_err_clr) r_err <= 1'b0;
    end
  end

  // NOTE: storage is not reset; r_count gates every read, so stale slots are never visible.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_new;
  end

endmodule

// File: rtl/lsu_wb_pipe.sv
// Multi-lane load-writeback stage: NUM_LANES independent lsu_wb_lane copies sharing flush/err_clr.
// LSU_WB_BYPASS_EN (in lsu_wb_lane) enables the zero-latency bypass of an empty FIFO.
module lsu_wb_pipe
  import lsu_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int XLEN      = 32,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 err_clr,
  output logic [NUM_LANES-1:0] err,
  lsu_wb_pipe_if.slave         bus
);

  if (XLEN != 32 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || NUM_LANES < 1) begin : g_param_check
    $error("lsu_wb_pipe: XLEN must be 32, DEPTH a power of two >= 2, NUM_LANES >= 1");
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lsu_wb_lane #(
      .DEPTH(DEPTH)
    ) u_lane (
      .clk          (clk),
      .rst          (rst),
      .i_flush      (flush),
      .i_err_clr    (err_clr),
      .i_rsp_valid  (bus.rsp_valid[g]),
      .o_rsp_ready  (bus.rsp_ready[g]),
      .i_rsp_is_load(bus.rsp_is_load[g]),
      .i_rsp_rd     (bus.rsp_rd[g]),
      .i_rsp_addr_lo(bus.rsp_addr_lo[g]),
      .i_rsp_size   (bus.rsp_size[g]),
      .i_rsp_zext   (bus.rsp_zext[g]),
      .i_rsp_data   (bus.rsp_data[g]),
      .o_wr_valid   (bus.wr_valid[g]),
      .i_wr_ready   (bus.wr_ready[g]),
      .o_wr_rd      (bus.wr_rd[g]),
      .o_wr_data    (bus.wr_data[g]),
      .o_err        (err[g])
    );
  end

endmodule

// File: tb/tb_lsu_wb_pipe.sv
// Self-checking bench for lsu_wb_pipe (default build: FIFO path, one-cycle minimum latency).
// Directed table vectors, hand-written stall/flush/reset sequences, then random traffic vs a queue model.
module tb_lsu_wb_pipe;
  import lsu_pkg::*;

  localparam int NL    = 2;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst, flush, err_clr;
  logic [NL-1:0] err;

  lsu_wb_pipe_if #(.NUM_LANES(NL)) bus ();

  lsu_wb_pipe #(
    .NUM_LANES(NL),
    .XLEN     (32),
    .DEPTH    (DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .err_clr(err_clr),
    .err    (err),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ln, input bit is_load, input int rd, input int off,
                       input int sz, input bit zext, input logic [31:0] data);
    bus.rsp_valid[ln]   = 1'b1;
    bus.rsp_is_load[ln] = is_load;
    bus.rsp_rd[ln]      = 5'(rd);
    bus.rsp_addr_lo[ln] = 2'(off);
    bus.rsp_size[ln]    = size_e'(2'(sz));
    bus.rsp_zext[ln]    = zext;
    bus.rsp_data[ln]    = data;
  endtask

  task automatic idle();
    bus.rsp_valid   = '0;
    bus.rsp_is_load = '0;
    bus.rsp_rd      = '0;
    bus.rsp_addr_lo = '0;
    for (int l = 0; l < NL; l++) bus.rsp_size[l] = SZ_B;
    bus.rsp_zext    = '0;
    bus.rsp_data    = '0;
    flush           = 1'b0;
    err_clr         = 1'b0;
  endtask

  // Reference extraction from the load rules: width in bytes, alignment, then two's-complement wrap.
  function automatic void ref_extract(input logic [31:0] data, input int off, input int sz,
                                      input bit zext, output bit ok, output logic [31:0] val);
    longint unsigned nbytes, raw, span;
    nbytes = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    ok     = (sz != 3) && ((off % nbytes) == 0) && !(zext && sz == 2);
    span   = 64'd1 << (8 * nbytes);
    raw    = data;
    raw    = (raw >> (8 * off)) % span;
    if (!zext && raw >= span / 2) raw = raw - span;
    val = raw[31:0];
  endfunction

  // Behavioural model: per-lane queue of pending writes, last written value, sticky error.
  lsu_wb_entry_t m_q[NL][$];
  lsu_wb_entry_t m_last[NL];
  bit            m_err[NL];

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      m_q[l].delete();
      m_last[l] = '0;
      m_err[l]  = 1'b0;
    end
  endtask

  // Stimulus the random phase applies this cycle; the model reads these, not the DUT.
  bit          s_valid[NL], s_load[NL], s_zext[NL], s_wrdy[NL], s_flush, s_clr, s_rst;
  int          s_rd[NL], s_off[NL], s_sz[NL];
  logic [31:0] s_data[NL];

  task automatic model_step();
    bit            ok, acc;
    logic [31:0]   val;
    lsu_wb_entry_t e;
    if (s_rst) begin
      model_reset();
      return;
    end
    for (int l = 0; l < NL; l++) begin
      acc = s_valid[l] && (m_q[l].size() < DEPTH);
      ref_extract(s_data[l], s_off[l], s_sz[l], s_zext[l], ok, val);
      if (s_wrdy[l] && m_q[l].size() > 0) m_last[l] = m_q[l].pop_front();
      if (s_flush) m_q[l].delete();
      else if (acc && s_load[l] && ok && s_rd[l] != 0) begin
        e.rd   = 5'(s_rd[l]);
        e.data = val;
        m_q[l].push_back(e);
      end
      if (acc && s_load[l] && !ok) m_err[l] = 1'b1;
      else if (s_clr)              m_err[l] = 1'b0;
    end
  endtask

  typedef struct {
    string       name;
    bit          is_load;
    int          rd;
    int          off;
    int          sz;
    bit          zext;
    logic [31:0] data;
    bit          exp_wr;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{"lb_neg_off3",   1'b1, 5,  3, 0, 1'b0, 32'h8000_0000, 1'b1, 32'hFFFF_FF80, 1'b0};
    vecs[1]  = '{"lhu_off2",      1'b1, 6,  2, 1, 1'b1, 32'hBEEF_1234, 1'b1, 32'h0000_BEEF, 1'b0};
    vecs[2]  = '{"lh_misalign",   1'b1, 6,  1, 1, 1'b0, 32'hBEEF_1234, 1'b0, 32'h0,         1'b1};
    vecs[3]  = '{"lb_pos_off0",   1'b1, 1,  0, 0, 1'b0, 32'h0000_007F, 1'b1, 32'h0000_007F, 1'b0};
    vecs[4]  = '{"lbu_off1",      1'b1, 2,  1, 0, 1'b1, 32'h0000_FF00, 1'b1, 32'h0000_00FF, 1'b0};
    vecs[5]  = '{"lh_neg_off0",   1'b1, 3,  0, 1, 1'b0, 32'h0000_8001, 1'b1, 32'hFFFF_8001, 1'b0};
    vecs[6]  = '{"lw",            1'b1, 4,  0, 2, 1'b0, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0};
    vecs[7]  = '{"lw_misalign",   1'b1, 4,  2, 2, 1'b0, 32'h1234_5678, 1'b0, 32'h0,         1'b1};
    vecs[8]  = '{"lw_zext",       1'b1, 4,  0, 2, 1'b1, 32'h1234_5678, 1'b0, 32'h0,         1'b1};
    vecs[9]  = '{"size_illegal",  1'b1, 4,  0, 3, 1'b0, 32'h1234_5678, 1'b0, 32'h0,         1'b1};
    vecs[10] = '{"load_rd0",      1'b1, 0,  0, 2, 1'b0, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b0};
    vecs[11] = '{"store_rd7",     1'b0, 7,  0, 2, 1'b0, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b0};
    vecs[12] = '{"lb_neg_off2",   1'b1, 31, 2, 0, 1'b0, 32'h00AB_0000, 1'b1, 32'hFFFF_FFAB, 1'b0};

    idle();
    bus.wr_ready = '1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_wr_valid", 32'(bus.wr_valid), 32'h0);
    check("reset_wr_rd0",   32'(bus.wr_rd[0]), 32'h0);
    check("reset_wr_data0", bus.wr_data[0], 32'h0);
    check("reset_err",      32'(err), 32'h0);
    check("reset_ready",    32'(bus.rsp_ready), 32'(2'b11));

    // Table vectors on lane 0: one-cycle latency, then err_clr and drain.
    for (int i = 0; i < 13; i++) begin
      drive(0, vecs[i].is_load, vecs[i].rd, vecs[i].off, vecs[i].sz, vecs[i].zext, vecs[i].data);
      tick();
      idle();
      err_clr = 1'b1;
      check({vecs[i].name, "_wr_valid"}, 32'(bus.wr_valid[0]), 32'(vecs[i].exp_wr));
      if (vecs[i].exp_wr) begin
        check({vecs[i].name, "_wr_rd"},   32'(bus.wr_rd[0]), 32'(vecs[i].rd));
        check({vecs[i].name, "_wr_data"}, bus.wr_data[0], vecs[i].exp_data);
      end
      check({vecs[i].name, "_err"}, 32'(err[0]), 32'(vecs[i].exp_err));
      tick();
      err_clr = 1'b0;
      check({vecs[i].name, "_drained"}, 32'(bus.wr_valid[0]), 32'h0);
      check({vecs[i].name, "_err_clr"}, 32'(err[0]), 32'h0);
    end

    // Backpressure: DEPTH=2 fills, third response refused, drains in order.
    bus.wr_ready = '0;
    drive(0, 1, 10, 0, 2, 0, 32'hAAAA_0001);
    tick();
    check("bp_ready_after1", 32'(bus.rsp_ready[0]), 32'h1);
    check("bp_head_rd",      32'(bus.wr_rd[0]), 32'd10);
    drive(0, 1, 11, 0, 2, 0, 32'hBBBB_0002);
    tick();
    check("bp_ready_full",   32'(bus.rsp_ready[0]), 32'h0);
    check("bp_head_stable",  bus.wr_data[0], 32'hAAAA_0001);
    drive(0, 1, 12, 0, 2, 0, 32'hCCCC_0003);
    tick();
    check("bp_ready_still0", 32'(bus.rsp_ready[0]), 32'h0);
    check("bp_head_held",    bus.wr_data[0], 32'hAAAA_0001);
    idle();
    bus.wr_ready = '1;
    tick();
    check("bp_second_rd",    32'(bus.wr_rd[0]), 32'd11);
    check("bp_second_data",  bus.wr_data[0], 32'hBBBB_0002);
    check("bp_ready_again",  32'(bus.rsp_ready[0]), 32'h1);
    tick();
    check("bp_empty",        32'(bus.wr_valid[0]), 32'h0);
    check("bp_hold_last",    bus.wr_data[0], 32'hBBBB_0002);
    tick();
    check("bp_third_dropped", 32'(bus.wr_valid[0]), 32'h0);

    // Flush with a full FIFO and a valid response pending.
    bus.wr_ready = '0;
    drive(0, 1, 13, 0, 2, 0, 32'h1111_1111);
    tick();
    drive(0, 1, 14, 0, 2, 0, 32'h2222_2222);
    tick();
    drive(0, 1, 15, 0, 2, 0, 32'h3333_3333);
    flush = 1'b1;
    tick();
    idle();
    check("flush_full_valid", 32'(bus.wr_valid[0]), 32'h0);
    check("flush_full_ready", 32'(bus.rsp_ready[0]), 32'h1);
    bus.wr_ready = '1;
    tick();
    check("flush_full_nowrite", 32'(bus.wr_valid[0]), 32'h0);

    // Flush discards a concurrent accepted push; a lane-1 error survives the flush.
    bus.wr_ready = '0;
    drive(0, 1, 16, 0, 2, 0, 32'h4444_4444);
    drive(1, 1, 9, 1, 2, 0, 32'h5555_5555);
    tick();
    idle();
    check("lane1_err_set", 32'(err[1]), 32'h1);
    check("lane1_no_write", 32'(bus.wr_valid[1]), 32'h0);
    drive(0, 1, 17, 0, 2, 0, 32'h6666_6666);
    flush = 1'b1;
    tick();
    idle();
    check("flush_push_valid", 32'(bus.wr_valid[0]), 32'h0);
    check("flush_keeps_err",  32'(err[1]), 32'h1);
    bus.wr_ready = '1;
    tick();
    check("flush_push_nowrite", 32'(bus.wr_valid[0]), 32'h0);

    // err_clr against a same-cycle new error, then on its own.
    drive(1, 1, 9, 0, 3, 0, 32'h0);
    err_clr = 1'b1;
    tick();
    idle();
    check("err_wins_clr", 32'(err[1]), 32'h1);
    err_clr = 1'b1;
    tick();
    idle();
    check("err_clr_alone", 32'(err[1]), 32'h0);

    // Reset mid-operation drops everything, outputs return to reset values.
    bus.wr_ready = '0;
    drive(0, 1, 20, 0, 2, 0, 32'h7777_7777);
    tick();
    drive(0, 1, 21, 0, 2, 0, 32'h8888_8888);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_valid", 32'(bus.wr_valid[0]), 32'h0);
    check("rst_mid_rd",    32'(bus.wr_rd[0]), 32'h0);
    check("rst_mid_data",  bus.wr_data[0], 32'h0);
    check("rst_mid_ready", 32'(bus.rsp_ready[0]), 32'h1);
    bus.wr_ready = '1;
    tick();
    check("rst_mid_nowrite", 32'(bus.wr_valid[0]), 32'h0);

    // Random traffic on both lanes against the queue model.
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      s_rst   = (cyc == 300);
      s_flush = ($urandom_range(0, 40) == 0);
      s_clr   = ($urandom_range(0, 7) == 0);
      for (int l = 0; l < NL; l++) begin
        int pick;
        s_valid[l] = ($urandom_range(0, 3) != 0);
        s_load[l]  = ($urandom_range(0, 7) != 0);
        s_rd[l]    = (($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 31));
        pick       = $urandom_range(0, 9);
        s_sz[l]    = (pick < 3) ? 0 : (pick < 6) ? 1 : (pick < 9) ? 2 : 3;
        s_off[l]   = $urandom_range(0, 3);
        if ($urandom_range(0, 2) != 0) s_off[l] = s_off[l] & ((s_sz[l] == 0) ? 3 : (s_sz[l] == 1) ? 2 : 0);
        s_zext[l]  = ($urandom_range(0, 3) == 0);
        s_data[l]  = $urandom;
        s_wrdy[l]  = ($urandom_range(0, 1) == 1);
        bus.rsp_valid[l]   = s_valid[l];
        bus.rsp_is_load[l] = s_load[l];
        bus.rsp_rd[l]      = 5'(s_rd[l]);
        bus.rsp_addr_lo[l] = 2'(s_off[l]);
        bus.rsp_size[l]    = size_e'(2'(s_sz[l]));
        bus.rsp_zext[l]    = s_zext[l];
        bus.rsp_data[l]    = s_data[l];
        bus.wr_ready[l]    = s_wrdy[l];
      end
      rst     = s_rst;
      flush   = s_flush;
      err_clr = s_clr;
      model_step();
      tick();
      for (int l = 0; l < NL; l++) begin
        lsu_wb_entry_t exp_e;
        exp_e = (m_q[l].size() > 0) ? m_q[l][0] : m_last[l];
        check($sformatf("rnd%0d_l%0d_ready", cyc, l), 32'(bus.rsp_ready[l]), 32'(m_q[l].size() < DEPTH));
        check($sformatf("rnd%0d_l%0d_valid", cyc, l), 32'(bus.wr_valid[l]), 32'(m_q[l].size() > 0));
        check($sformatf("rnd%0d_l%0d_rd", cyc, l),    32'(bus.wr_rd[l]), 32'(exp_e.rd));
        check($sformatf("rnd%0d_l%0d_data", cyc, l),  bus.wr_data[l], exp_e.data);
        check($sformatf("rnd%0d_l%0d_err", cyc, l),   32'(err[l]), 32'(m_err[l]));
      end
    end
    idle();
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
